// File: rtl/fifo_rd_checker_if.sv
// Read-port bundle of the dual-clock FIFO as seen from the read clock domain.
// The checker pops through the master modport; the FIFO (or a bench model)
// sits on the slave side and presents a show-ahead head word.
interface fifo_rd_checker_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_empty;
  logic             fifo_rd_en;

  modport master (
    input  fifo_data,
    input  fifo_empty,
    output fifo_rd_en
  );

  modport slave (
    output fifo_data,
    output fifo_empty,
    input  fifo_rd_en
  );
endinterface

// File: rtl/fifo_rd_checker.sv
// Read-side consumer for the dual-clock FIFO. Pops words from the show-ahead
// port and checks them against the ramp BASE + k (mod 2^WIDTH). Reports the
// received count, error count, first failure, starvation timeout and pass.
// An optional GAP of idle cycles after every pop lets the FIFO fill up.
module fifo_rd_checker #(
  parameter int WIDTH     = 8,
  parameter int BASE      = 10,
  parameter int NUM_WORDS = 128,
  parameter int GAP       = 0,
  parameter int TIMEOUT   = 1024,
  parameter int CNT_W     = 16
) (
  input  logic                  rd_clk,
  input  logic                  rst,
  input  logic                  start,
  fifo_rd_checker_if.master     fifo,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [CNT_W-1:0]      rx_count,
  output logic [CNT_W-1:0]      err_count,
  output logic [CNT_W-1:0]      first_err_idx,
  output logic [WIDTH-1:0]      first_err_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] BASE_V  = WIDTH'(BASE);
  localparam logic [CNT_W-1:0] NUM_V   = CNT_W'(NUM_WORDS);
  localparam logic [CNT_W-1:0] GAP_V   = CNT_W'(GAP);
  localparam logic [CNT_W-1:0] TMO_V   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [WIDTH-1:0] DAT_ONE = WIDTH'(1);
  localparam bit               TMO_EN  = (TIMEOUT != 0);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] expected;
  logic [CNT_W-1:0] gap_cnt;
  logic [CNT_W-1:0] idle_cnt;

  logic             pop;
  logic             start_run;
  logic             last_pop;
  logic             tmo_hit;
  logic             mismatch;
  logic [CNT_W-1:0] rx_next;

  // Shared decode of the current cycle: pop permission, run entry, end conditions.
  always_comb begin
    pop       = (state == ST_RUN) && !fifo.fifo_empty && (gap_cnt == '0);
    start_run = ((state == ST_IDLE) || (state == ST_DONE)) && start;
    rx_next   = rx_count + CNT_ONE;
    last_pop  = pop && (rx_next == NUM_V);
    tmo_hit   = TMO_EN && (idle_cnt == TMO_V);
    mismatch  = (fifo.fifo_data != expected);
  end

  // State register.
  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; completion has priority over a coincident timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_RUN;
        else       state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (last_pop)     state_nxt = ST_DONE;
        else if (tmo_hit) state_nxt = ST_DONE;
        else              state_nxt = ST_RUN;
      end
      ST_DONE: begin
        if (start) state_nxt = ST_RUN;
        else       state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: pop strobe is combinational so the FIFO advances on the same edge.
  always_comb begin
    fifo.fifo_rd_en = pop;
    busy            = (state == ST_RUN);
    done            = (state == ST_DONE);
    pass            = (state == ST_DONE) && (err_count == '0) && !timeout;
  end

  // Run datapath: ramp tracking, counters, first-error capture, throttle and starvation.
  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      expected       <= BASE_V;
      gap_cnt        <= '0;
      idle_cnt       <= '0;
      rx_count       <= '0;
      err_count      <= '0;
      first_err_idx  <= '0;
      first_err_data <= '0;
      timeout        <= 1'b0;
    end else if (start_run) begin
      expected       <= BASE_V;
      gap_cnt        <= '0;
      idle_cnt       <= '0;
      rx_count       <= '0;
      err_count      <= '0;
      first_err_idx  <= '0;
      first_err_data <= '0;
      timeout        <= 1'b0;
    end else if (state == ST_RUN) begin
      if (pop) begin
        rx_count <= rx_next;
        expected <= expected + DAT_ONE;
        gap_cnt  <= GAP_V;
        idle_cnt <= '0;
        if (mismatch) begin
          if (err_count != CNT_MAX) err_count <= err_count + CNT_ONE;
          // err_count still zero means this is the first mismatch of the run
          if (err_count == '0) begin
            first_err_idx  <= rx_count;
            first_err_data <= fifo.fifo_data;
          end
        end
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - CNT_ONE;
      end else if (fifo.fifo_empty && (idle_cnt != CNT_MAX)) begin
        idle_cnt <= idle_cnt + CNT_ONE;
      end
      if (tmo_hit && !last_pop) timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_rd_checker.sv
// Bench for fifo_rd_checker: two instances (fast ramp with wrap and timeout,
// throttled ramp without timeout) fed from queue-based FIFO models, with a
// run-level reference model checked every cycle plus directed end-of-run values.
module tb_fifo_rd_checker;

  logic clk = 1'b0;
  logic rst;
  logic start_a, start_b;
  always #5 clk = ~clk;

  fifo_rd_checker_if #(.WIDTH(8)) fa ();
  fifo_rd_checker_if #(.WIDTH(8)) fb ();

  logic        busy_a, done_a, pass_a, tmo_a;
  logic [15:0] rx_a, err_a, fidx_a;
  logic [7:0]  fdat_a;
  logic        busy_b, done_b, pass_b, tmo_b;
  logic [15:0] rx_b, err_b, fidx_b;
  logic [7:0]  fdat_b;

  fifo_rd_checker #(.WIDTH(8), .BASE(250), .NUM_WORDS(16), .GAP(0), .TIMEOUT(8), .CNT_W(16)) dut_a (
    .rd_clk(clk), .rst(rst), .start(start_a), .fifo(fa.master),
    .busy(busy_a), .done(done_a), .pass(pass_a), .timeout(tmo_a),
    .rx_count(rx_a), .err_count(err_a), .first_err_idx(fidx_a), .first_err_data(fdat_a));

  fifo_rd_checker #(.WIDTH(8), .BASE(10), .NUM_WORDS(16), .GAP(3), .TIMEOUT(0), .CNT_W(16)) dut_b (
    .rd_clk(clk), .rst(rst), .start(start_b), .fifo(fb.master),
    .busy(busy_b), .done(done_b), .pass(pass_b), .timeout(tmo_b),
    .rx_count(rx_b), .err_count(err_b), .first_err_idx(fidx_b), .first_err_data(fdat_b));

  // Reference model: run phase (0 idle, 1 running, 2 finished) and run results.
  typedef struct {
    int st;
    int rx;
    int errs;
    int fidx;
    int fdata;
    int since;   // cycles since the last pop, capped at the gap length
    int starve;  // starved cycles since the last pop or run start
    bit tmo;
  } mdl_t;

  mdl_t ma, mb;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   src_a[$];
  int   src_b[$];
  bit   stall_a, stall_b, stall_en_a, stall_en_b;
  int   cyc = 0;
  int   pops_a, first_a, last_a, pops_b, first_b, last_b;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic mdl_t mreset();
    mdl_t m;
    m.st = 0; m.rx = 0; m.errs = 0; m.fidx = 0; m.fdata = 0;
    m.since = 0; m.starve = 0; m.tmo = 1'b0;
    return m;
  endfunction

  // One read-clock cycle of the consumer as described by its rules.
  task automatic mstep(input mdl_t m, input bit start, input bit empty, input int data,
                       input int base, input int nw, input int gap, input int tl,
                       output mdl_t n, output bit pop);
    n   = m;
    pop = (m.st == 1) && !empty && (m.since >= gap);
    if (m.st != 1) begin
      if (start) begin
        n = mreset();
        n.st = 1;
        n.since = gap;
      end
    end else begin
      if (pop) begin
        if (data != (base + m.rx) % 256) begin
          if (m.errs == 0) begin
            n.fidx  = m.rx;
            n.fdata = data;
          end
          n.errs = (m.errs < 65535) ? m.errs + 1 : 65535;
        end
        n.rx     = m.rx + 1;
        n.since  = 0;
        n.starve = 0;
      end else begin
        if (m.since < gap) n.since = m.since + 1;
        if (m.since >= gap && empty) n.starve = m.starve + 1;
      end
      if (pop && (m.rx + 1 == nw)) begin
        n.st = 2;
      end else if (tl != 0 && m.starve == tl) begin
        n.st  = 2;
        n.tmo = 1'b1;
      end
    end
  endtask

  task automatic check_out(input string p, input mdl_t m, input logic b, input logic d,
                           input logic ps, input logic t, input logic [15:0] rx,
                           input logic [15:0] er, input logic [15:0] fi, input logic [7:0] fd);
    chk({p, "_busy"},  b,  m.st == 1);
    chk({p, "_done"},  d,  m.st == 2);
    chk({p, "_pass"},  ps, (m.st == 2) && (m.errs == 0) && !m.tmo);
    chk({p, "_tmo"},   t,  m.tmo);
    chk({p, "_rx"},    rx, m.rx);
    chk({p, "_err"},   er, m.errs);
    chk({p, "_fidx"},  fi, m.fidx);
    chk({p, "_fdata"}, fd, m.fdata);
  endtask

  task automatic drive();
    fa.fifo_empty = stall_a || (src_a.size() == 0);
    fa.fifo_data  = (src_a.size() != 0) ? 8'(src_a[0]) : 8'h00;
    fb.fifo_empty = stall_b || (src_b.size() == 0);
    fb.fifo_data  = (src_b.size() != 0) ? 8'(src_b[0]) : 8'h00;
  endtask

  // Check at the falling edge, advance at the rising edge, refresh inputs just after it.
  task automatic cycle();
    mdl_t na, nb;
    bit   pa, pb;
    @(negedge clk);
    mstep(ma, start_a, fa.fifo_empty, int'(fa.fifo_data), 250, 16, 0, 8, na, pa);
    mstep(mb, start_b, fb.fifo_empty, int'(fb.fifo_data), 10, 16, 3, 0, nb, pb);
    chk("a_rd_en", fa.fifo_rd_en, pa);
    chk("b_rd_en", fb.fifo_rd_en, pb);
    check_out("a", ma, busy_a, done_a, pass_a, tmo_a, rx_a, err_a, fidx_a, fdat_a);
    check_out("b", mb, busy_b, done_b, pass_b, tmo_b, rx_b, err_b, fidx_b, fdat_b);
    if (fa.fifo_rd_en === 1'b1) begin
      pops_a++;
      if (first_a < 0) first_a = cyc;
      last_a = cyc;
    end
    if (fb.fifo_rd_en === 1'b1) begin
      pops_b++;
      if (first_b < 0) first_b = cyc;
      last_b = cyc;
    end
    cyc++;
    @(posedge clk);
    #1;
    if (pa && src_a.size() != 0) void'(src_a.pop_front());
    if (pb && src_b.size() != 0) void'(src_b.pop_front());
    ma = na;
    mb = nb;
    stall_a = stall_en_a && ($urandom_range(0, 3) == 0);
    stall_b = stall_en_b && ($urandom_range(0, 3) == 0);
    drive();
  endtask

  // Fill a source with a ramp; bad_idx gets 8'h11 instead, p_corrupt adds random damage.
  task automatic load_a(input int bad_idx, input int nwords, input int p_corrupt);
    src_a.delete();
    for (int k = 0; k < nwords; k++) begin
      if (k == bad_idx) src_a.push_back(8'h11);
      else if (p_corrupt != 0 && $urandom_range(0, p_corrupt) == 0) src_a.push_back(int'($urandom_range(0, 255)));
      else src_a.push_back((250 + k) % 256);
    end
    drive();
  endtask

  task automatic load_b(input int nwords);
    src_b.delete();
    for (int k = 0; k < nwords; k++) src_b.push_back((10 + k) % 256);
    drive();
  endtask

  task automatic run_a(input string tag);
    pops_a = 0; first_a = -1; last_a = -1;
    start_a = 1'b1;
    cycle();
    start_a = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (ma.st == 2) break;
      cycle();
    end
    chk({tag, "_done_reached"}, done_a, 1'b1);
  endtask

  task automatic run_b(input string tag);
    pops_b = 0; first_b = -1; last_b = -1;
    start_b = 1'b1;
    cycle();
    start_b = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (mb.st == 2) break;
      cycle();
    end
    chk({tag, "_done_reached"}, done_b, 1'b1);
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    stall_a = 1'b0; stall_b = 1'b0; stall_en_a = 1'b0; stall_en_b = 1'b0;
    ma = mreset(); mb = mreset();
    drive();
    #2;
    check_out("rst_a", ma, busy_a, done_a, pass_a, tmo_a, rx_a, err_a, fidx_a, fdat_a);
    chk("rst_a_rd_en", fa.fifo_rd_en, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    cycle();

    // Clean ramp with wrap: 250..255 then 0..9, popped back to back.
    load_a(-1, 16, 0);
    run_a("clean");
    chk("clean_pops", pops_a, 16);
    chk("clean_span", last_a - first_a + 1, 16);
    chk("clean_rx", rx_a, 16);
    chk("clean_err", err_a, 0);
    chk("clean_pass", pass_a, 1'b1);
    for (int i = 0; i < 3; i++) cycle();

    // Single corruption at index 5 with random stalls; restart from DONE.
    stall_en_a = 1'b1;
    load_a(5, 20, 0);
    run_a("corrupt");
    chk("corrupt_err", err_a, 1);
    chk("corrupt_fidx", fidx_a, 5);
    chk("corrupt_fdata", fdat_a, 8'h11);
    chk("corrupt_pass", pass_a, 1'b0);
    chk("corrupt_left", src_a.size(), 4);
    stall_en_a = 1'b0;
    stall_a = 1'b0;

    // Starvation: only four words ever arrive.
    load_a(-1, 4, 0);
    run_a("starve");
    chk("starve_tmo", tmo_a, 1'b1);
    chk("starve_rx", rx_a, 4);
    chk("starve_pass", pass_a, 1'b0);

    // Random runs: random stalls, random corruption, sometimes short supply.
    stall_en_a = 1'b1;
    for (int r = 0; r < 5; r++) begin
      load_a(-1, (r == 2) ? 11 : 16 + int'($urandom_range(0, 4)), 6);
      run_a("rand");
    end
    stall_en_a = 1'b0;
    stall_a = 1'b0;

    // Throttle on B: one pop every four cycles, FIFO never empty.
    load_b(20);
    run_b("thr");
    chk("thr_pops", pops_b, 16);
    chk("thr_span", last_b - first_b + 1, 61);
    chk("thr_pass", pass_b, 1'b1);
    stall_en_b = 1'b1;
    load_b(16);
    run_b("thr_rand");
    chk("thr_rand_pass", pass_b, 1'b1);
    stall_en_b = 1'b0;
    stall_b = 1'b0;

    // Reset in the middle of a run, then a fresh clean run.
    load_a(-1, 16, 0);
    start_a = 1'b1;
    cycle();
    start_a = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ma.rx >= 7) break;
      cycle();
    end
    chk("mid_rx_before_rst", rx_a, 7);
    rst = 1'b1;
    #1;
    ma = mreset(); mb = mreset();
    check_out("midrst_a", ma, busy_a, done_a, pass_a, tmo_a, rx_a, err_a, fidx_a, fdat_a);
    chk("midrst_rd_en", fa.fifo_rd_en, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    load_a(-1, 16, 0);
    run_a("restart");
    chk("restart_rx", rx_a, 16);
    chk("restart_pass", pass_a, 1'b1);
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_checker.md
Name: fifo_rd_checker

Overview:
- Read-side consumer for the team's dual-clock FIFO; runs entirely in the read clock domain.
- Pops words from the FIFO's show-ahead read port and checks each one against the ramp pattern the write-side source generates (BASE + index).
- Reports received-word count, error count, first-failure details, timeout and pass/fail.
- Optional read throttling forces the FIFO to fill, so the full-flag path gets exercised.

Parameters:
WIDTH, 8, FIFO data width.
BASE, 10, expected value of word 0; word k must equal (BASE + k) mod 2^WIDTH.
NUM_WORDS, 128, number of words to consume per run (1..2^CNT_W-1).
GAP, 0, idle cycles forced after every pop (0 = pop every cycle data is available).
TIMEOUT, 1024, consecutive starved cycles in RUN before abort (0 = disabled).
CNT_W, 16, width of all counters.

Ports:
rd_clk  input  1  read-domain clock; everything is posedge rd_clk.
rst  input  1  asynchronous, active-high reset.
start  input  1  level-sampled; starts a run from IDLE or DONE.
fifo_data  input  WIDTH  FIFO head word, valid whenever fifo_empty=0 (show-ahead).
fifo_empty  input  1  FIFO read_empty flag, already synchronised into rd_clk.
fifo_rd_en  output  1  pop strobe, combinational; the FIFO advances on the same edge.
busy  output  1  high in RUN.
done  output  1  high in DONE.
pass  output  1  done & err_count==0 & !timeout.
timeout  output  1  run aborted by starvation; sticky until next start.
rx_count  output  CNT_W  words popped this run.
err_count  output  CNT_W  mismatches this run; saturates at all-ones.
first_err_idx  output  CNT_W  index of first mismatching word.
first_err_data  output  WIDTH  data value of first mismatching word.

Behaviour:
- Reset (async, immediate): state=IDLE; all outputs 0; internal expected=BASE, gap_cnt=0, idle_cnt=0.
- States and transitions:
  - IDLE: start=1 -> RUN.
  - RUN: rx_count==NUM_WORDS after a pop -> DONE; idle_cnt==TIMEOUT (TIMEOUT!=0) -> DONE with timeout=1. start is ignored.
  - DONE: outputs hold; start=1 -> RUN.
- Entry into RUN from IDLE or DONE, on the same edge:
  - Clear rx_count, err_count, first_err_*, timeout, gap_cnt, idle_cnt.
  - Set expected=BASE.
- Pop rule: fifo_rd_en = (state==RUN) & !fifo_empty & (gap_cnt==0). The output is never asserted while fifo_empty=1 or outside RUN.
- On each edge with fifo_rd_en=1:
  - Compare fifo_data with expected.
  - rx_count+1; expected+1, wrapping mod 2^WIDTH.
  - gap_cnt=GAP; idle_cnt=0.
  - On mismatch: err_count+1 unless it is all-ones.
  - On the first mismatch of the run: capture first_err_idx=rx_count (pre-increment value) and first_err_data=fifo_data.
- Pop that brings rx_count to NUM_WORDS: state goes to DONE on that edge and done rises the following cycle. No further pops, even if the FIFO still holds data.
- Throttle: gap_cnt decrements by 1 per cycle while nonzero; no pop while gap_cnt!=0.
- Timeout counter: idle_cnt increments only when state==RUN, gap_cnt==0 and fifo_empty=1. It is cleared on a pop and on entry to RUN.
- If the final pop and the timeout coincide, completion wins: timeout=0.
- Reset asserted mid-run aborts immediately to the reset state. No partial results are kept.
- Latency: start to first possible fifo_rd_en is 1 cycle. Last pop to done=1 is 1 cycle.
- Error accounting is positional: a dropped or duplicated word shifts all later words, and every subsequent word counts as a mismatch.

Test Plan:
- Clean ramp: NUM_WORDS=16, GAP=0; FIFO supplies 10..25 continuously -> 16 consecutive fifo_rd_en pulses; done=1, rx_count=16, err_count=0, pass=1.
- Single corruption: word index 5 returns 0xFF instead of 15 -> err_count=1, first_err_idx=5, first_err_data=0xFF, pass=0.
- Throttle: GAP=3, FIFO never empty -> fifo_rd_en high exactly 1 cycle in 4; 16 words take 61 cycles from the first pop; pass=1.
- Starvation: TIMEOUT=8, FIFO goes empty after 4 words -> done after 8 empty cycles; timeout=1, rx_count=4, pass=0.
- Wrap: BASE=250, NUM_WORDS=10; data 250..255, then 0..3 -> err_count=0, pass=1.
- Reset and restart: assert rst at word 7 -> all outputs 0 asynchronously. Then start -> new run begins at expected=BASE. Also pulse start in DONE -> counters clear and a second run passes.
